// File: rtl/frame_dump_pkg.sv
// Shared types and default sizing for the frame dump controller.
package frame_dump_pkg;

  // Controller FSM encoding; exported as the 3-bit debug state output.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SKIP     = 3'd1,
    ST_WAIT_SOF = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_RD_ADDR  = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_SEND     = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  // 640x480 sensor, two settle frames, roughly one UART character of holdoff.
  localparam int unsigned DEF_FRAME_PIXELS = 307200;
  localparam int unsigned DEF_ADDR_W       = 20;
  localparam int unsigned DEF_SKIP_FRAMES  = 2;
  localparam int unsigned DEF_HOLDOFF      = 8191;

endpackage

// File: rtl/tx_pacer.sv
// UART pacing: counts idle cycles (tx_busy low, no write) and grants a send
// permit once HOLDOFF such cycles have elapsed and the UART is still idle.
module tx_pacer
  import frame_dump_pkg::*;
#(
  parameter int unsigned HOLDOFF = DEF_HOLDOFF
) (
  input  logic clk,
  input  logic resetn,
  input  logic tx_busy,
  input  logic tx_we,
  output logic permit
);

  localparam int unsigned CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(HOLDOFF);

  logic [CW-1:0] holdoff_cnt;

  // Idle counter: restarts on any UART activity, saturates at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      holdoff_cnt <= '0;
    end else if (tx_busy || tx_we) begin
      holdoff_cnt <= '0;
    end else if (holdoff_cnt != LIMIT) begin
      holdoff_cnt <= holdoff_cnt + CW'(1);
    end
  end

  assign permit = (holdoff_cnt == LIMIT) && !tx_busy;

endmodule

// File: rtl/frame_dump_ctrl.sv
// Frame dump controller: after arm, discards settle frames, captures one CSI
// frame into a byte buffer, then replays the buffer byte by byte to a UART.
//
// UART handshake: tx_we is a one-cycle write strobe carrying tx_data; it is
// only raised when tx_busy is low and the pacer has seen HOLDOFF idle cycles.
// tx_busy from the UART is the back-pressure; there is no other ready signal.
module frame_dump_ctrl
  import frame_dump_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned SKIP_FRAMES  = DEF_SKIP_FRAMES,
  parameter int unsigned HOLDOFF      = DEF_HOLDOFF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              arm,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [7:0]        buf_rdata,
  output logic              tx_we,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [2:0]        state
);

  localparam int unsigned SKW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [ADDR_W-1:0] FP_LIMIT = ADDR_W'(FRAME_PIXELS);

  state_t state_q, state_d;

  logic [SKW-1:0]    skip_cnt;
  logic [ADDR_W-1:0] wcount;
  logic [ADDR_W-1:0] raddr;

  // Datapath strobes decoded by the FSM.
  logic start, dec_skip, clr_wcount, wr_pix, set_ovf, clr_raddr, latch_tx, fire;
  logic permit;

  tx_pacer #(
    .HOLDOFF(HOLDOFF)
  ) u_pacer (
    .clk    (clk),
    .resetn (resetn),
    .tx_busy(tx_busy),
    .tx_we  (tx_we),
    .permit (permit)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobe decode.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    dec_skip   = 1'b0;
    clr_wcount = 1'b0;
    wr_pix     = 1'b0;
    set_ovf    = 1'b0;
    clr_raddr  = 1'b0;
    latch_tx   = 1'b0;
    fire       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          start = 1'b1;
          if (SKIP_FRAMES == 0) state_d = ST_WAIT_SOF;
          else                  state_d = ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (frame_end) begin
          dec_skip = 1'b1;
          if (skip_cnt == SKW'(1)) state_d = ST_WAIT_SOF;
        end
      end
      ST_WAIT_SOF: begin
        if (frame_start) begin
          clr_wcount = 1'b1;
          state_d    = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // A pixel coinciding with frame_end is still captured.
        if (pix_valid) begin
          if (wcount < FP_LIMIT) wr_pix  = 1'b1;
          else                   set_ovf = 1'b1;
        end
        if (frame_end) begin
          clr_raddr = 1'b1;
          state_d   = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        if (raddr == wcount) state_d = ST_DONE;
        else                 state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        latch_tx = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (permit) begin
          fire    = 1'b1;
          state_d = ST_RD_ADDR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters, buffer write port and UART byte register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skip_cnt  <= '0;
      wcount    <= '0;
      raddr     <= '0;
      buf_we    <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
      tx_we     <= 1'b0;
      tx_data   <= '0;
      overflow  <= 1'b0;
    end else begin
      buf_we <= 1'b0;
      tx_we  <= 1'b0;
      if (start) begin
        skip_cnt <= SKW'(SKIP_FRAMES);
        overflow <= 1'b0;
      end
      if (dec_skip)   skip_cnt <= skip_cnt - SKW'(1);
      if (clr_wcount) wcount   <= '0;
      if (wr_pix) begin
        buf_we    <= 1'b1;
        buf_waddr <= wcount;
        buf_wdata <= pix_data;
        wcount    <= wcount + ADDR_W'(1);
      end
      if (set_ovf)   overflow <= 1'b1;
      if (clr_raddr) raddr    <= '0;
      if (latch_tx)  tx_data  <= buf_rdata;
      if (fire) begin
        tx_we <= 1'b1;
        raddr <= raddr + ADDR_W'(1);
      end
    end
  end

  assign buf_raddr = raddr;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign state     = state_q;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Bench for frame_dump_ctrl with a small frame: buffer and UART models,
// a scoreboard for buffer writes and transmitted bytes, and a table of
// capture scenarios followed by a reset-during-send sequence.
module tb_frame_dump_ctrl;

  localparam int FP       = 16;
  localparam int AW       = 20;
  localparam int SF       = 1;
  localparam int HO       = 4;
  localparam int BUSY_CYC = 10;

  // Clock / reset and DUT signals.
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          arm = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic          pix_valid = 1'b0;
  logic [7:0]    pix_data = 8'h00;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [7:0]    buf_wdata;
  logic [AW-1:0] buf_raddr;
  logic [7:0]    buf_rdata;
  logic          tx_we;
  logic [7:0]    tx_data;
  logic          tx_busy = 1'b0;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [2:0]    state;

  always #5 clk = ~clk;

  frame_dump_ctrl #(
    .FRAME_PIXELS(FP),
    .ADDR_W      (AW),
    .SKIP_FRAMES (SF),
    .HOLDOFF     (HO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .arm        (arm),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .buf_we     (buf_we),
    .buf_waddr  (buf_waddr),
    .buf_wdata  (buf_wdata),
    .buf_raddr  (buf_raddr),
    .buf_rdata  (buf_rdata),
    .tx_we      (tx_we),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .state      (state)
  );

  // Buffer RAM model: synchronous write, one-cycle read latency.
  logic [7:0] mem [0:31];
  always @(posedge clk) begin
    if (buf_we) mem[buf_waddr[4:0]] <= buf_wdata;
    buf_rdata <= mem[buf_raddr[4:0]];
  end

  // Scoreboard state.
  int tests = 0;
  int fails = 0;
  int wr_seen = 0;
  int tx_seen = 0;
  int done_cnt = 0;
  int idle_run = 0;
  int busy_cnt = 0;
  logic [AW+7:0] exp_wr_q[$];
  logic [7:0]    exp_tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor + UART model, sampled on the falling edge.
  always @(negedge clk) begin
    if (buf_we) begin
      if (exp_wr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required none", buf_waddr, buf_wdata);
      end else begin
        logic [AW+7:0] e;
        e = exp_wr_q.pop_front();
        check("buf_write", 32'({buf_waddr, buf_wdata}), 32'(e));
      end
      wr_seen++;
    end
    if (tx_we) begin
      check("tx_holdoff", 32'(idle_run >= HO), 32'd1);
      check("tx_while_busy", 32'(tx_busy), 32'd0);
      if (exp_tx_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_tx: got %0h, required none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_tx_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(e));
      end
      tx_seen++;
      idle_run = 0;
      busy_cnt = BUSY_CYC;
      tx_busy  = 1'b1;
    end else begin
      if (!tx_busy) idle_run++;
      else          idle_run = 0;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
    end
    if (done) done_cnt++;
  end

  // Driver: apply one cycle of inputs, aligned just after the rising edge.
  task automatic cycle_in(input logic a, input logic fs, input logic fe,
                          input logic pv, input logic [7:0] pd);
    arm = a; frame_start = fs; frame_end = fe; pix_valid = pv; pix_data = pd;
    @(posedge clk); #1;
    arm = 1'b0; frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_buf_we"}, 32'(buf_we), 32'd0);
    check({tag, "_tx_we"}, 32'(tx_we), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_buf_waddr"}, 32'(buf_waddr), 32'd0);
    check({tag, "_buf_wdata"}, 32'(buf_wdata), 32'd0);
    check({tag, "_buf_raddr"}, 32'(buf_raddr), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
  endtask

  // Scenario record: stimulus shape and hand-computed outcome.
  typedef struct {
    int         n_pix;
    bit         eof_last;
    bit         mid_sof;
    logic [7:0] base;
    int         exp_wr;
    int         exp_tx;
    bit         exp_ovf;
  } vec_t;

  vec_t vecs[5];

  // Arm, discard one settle frame, poke ignored markers, capture a frame.
  task automatic arm_and_capture(input vec_t v);
    for (int i = 0; i < v.exp_wr; i++) begin
      exp_wr_q.push_back({AW'(i), 8'(v.base + 8'(i))});
      exp_tx_q.push_back(8'(v.base + 8'(i)));
    end
    cycle_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("arm_clears_overflow", 32'(overflow), 32'd0);
    check("arm_to_skip", 32'(state), 32'd1);
    check("busy_after_arm", 32'(busy), 32'd1);
    cycle_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cycle_in(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'hA0 + 8'(i)));
    cycle_in(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("skip_to_wait_sof", 32'(state), 32'd2);
    cycle_in(1'b0, 1'b0, 1'b1, 1'b1, 8'hEE);
    check("wait_sof_holds", 32'(state), 32'd2);
    cycle_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("sof_to_capture", 32'(state), 32'd3);
    for (int i = 0; i < v.n_pix; i++) begin
      if (v.mid_sof && i == v.n_pix / 2) cycle_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      cycle_in(1'b0, 1'b0, v.eof_last && (i == v.n_pix - 1), 1'b1, 8'(v.base + 8'(i)));
      if (i % 4 == 3) idle(1);
    end
    if (!v.eof_last || v.n_pix == 0) cycle_in(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic run_scenario(input vec_t v, input int idx);
    int wr0, tx0, d0, cyc;
    wr0 = wr_seen; tx0 = tx_seen; d0 = done_cnt;
    arm_and_capture(v);
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("v%0d_done_timeout", idx), 32'(done_cnt - d0), 32'd1);
    idle(2);
    check($sformatf("v%0d_done_once", idx), 32'(done_cnt - d0), 32'd1);
    check($sformatf("v%0d_writes", idx), 32'(wr_seen - wr0), 32'(v.exp_wr));
    check($sformatf("v%0d_sent", idx), 32'(tx_seen - tx0), 32'(v.exp_tx));
    check($sformatf("v%0d_overflow", idx), 32'(overflow), 32'(v.exp_ovf));
    check($sformatf("v%0d_idle", idx), 32'(state), 32'd0);
    check($sformatf("v%0d_wr_q_empty", idx), 32'(exp_wr_q.size()), 32'd0);
    check($sformatf("v%0d_tx_q_empty", idx), 32'(exp_tx_q.size()), 32'd0);
  endtask

  // Test sequence.
  initial begin
    vecs[0] = '{n_pix: 16, eof_last: 1'b0, mid_sof: 1'b0, base: 8'h00, exp_wr: 16, exp_tx: 16, exp_ovf: 1'b0};
    vecs[1] = '{n_pix: 20, eof_last: 1'b0, mid_sof: 1'b0, base: 8'h40, exp_wr: 16, exp_tx: 16, exp_ovf: 1'b1};
    vecs[2] = '{n_pix: 5,  eof_last: 1'b1, mid_sof: 1'b0, base: 8'h80, exp_wr: 5,  exp_tx: 5,  exp_ovf: 1'b0};
    vecs[3] = '{n_pix: 0,  eof_last: 1'b0, mid_sof: 1'b0, base: 8'h00, exp_wr: 0,  exp_tx: 0,  exp_ovf: 1'b0};
    vecs[4] = '{n_pix: 10, eof_last: 1'b0, mid_sof: 1'b1, base: 8'hC0, exp_wr: 10, exp_tx: 10, exp_ovf: 1'b0};

    resetn = 1'b0;
    idle(3);
    check_reset_outputs("por");
    resetn = 1'b1;
    idle(3);
    check("idle_without_arm", 32'(state), 32'd0);

    for (int k = 0; k < 5; k++) run_scenario(vecs[k], k);

    // Reset during the send phase, after the seventh byte.
    begin
      vec_t v;
      int tx0, cyc, tx_at_reset;
      v = '{n_pix: 16, eof_last: 1'b0, mid_sof: 1'b0, base: 8'h10, exp_wr: 16, exp_tx: 16, exp_ovf: 1'b0};
      tx0 = tx_seen;
      arm_and_capture(v);
      cyc = 0;
      while (tx_seen - tx0 < 7 && cyc < 2000) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("rst_reach_byte7", 32'(tx_seen - tx0), 32'd7);
      cycle_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      check("arm_while_busy_ignored", 32'(state == 3'd1), 32'd0);
      check("busy_during_send", 32'(busy), 32'd1);
      resetn = 1'b0;
      #2;
      check_reset_outputs("midsend");
      exp_wr_q.delete();
      exp_tx_q.delete();
      tx_at_reset = tx_seen;
      idle(3);
      resetn = 1'b1;
      idle(30);
      check("no_tx_after_reset", 32'(tx_seen - tx_at_reset), 32'd0);
      check("idle_after_reset", 32'(state), 32'd0);
      check("ovf_after_reset", 32'(overflow), 32'd0);
    end

    run_scenario(vecs[0], 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
